// File: rtl/ymem_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
// State and owner codes, minimum latency and an alignment helper.
package ymem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int MEM_LAT_MIN = 1;

  // Data accesses are word-sized; any nonzero low address bit is illegal.
  function automatic logic word_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner pick: data wins unless fetch has been starved for
// the maximum streak of data grants.
module mem_arb_pick
  import ymem_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic dstreak_max,
  output logic any_req,
  output logic owner
);

  logic pick_dm;

  assign any_req = if_req | dm_req;
  assign pick_dm = dm_req & ~(if_req & dstreak_max);
  assign owner   = pick_dm ? OWN_DM : OWN_IF;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// access; one transaction at a time, stalling the PC while requests wait.
module mem_port_arbiter
  import ymem_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic          dm_err,
  output logic [DW-1:0] dm_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall
);

  localparam int LAT  = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN : MEM_LAT;
  localparam int MAXD = (MAX_DSTREAK < 1) ? 1 : MAX_DSTREAK;
  localparam int CW   = $clog2(LAT) + 1;
  localparam int SW   = $clog2(MAXD) + 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAXD);

  state_t        state_reg, state_next;
  owner_t        owner_reg, owner_next;
  logic          we_reg, we_next;
  logic          err_reg, err_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [SW-1:0] dstreak_reg, dstreak_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;

  logic pick_any;
  logic pick_owner;
  logic dstreak_max;
  logic busy;
  logic first_busy;
  logic done;

  assign dstreak_max = (dstreak_reg == STREAK_MAX);

  mem_arb_pick u_pick (
    .if_req      (if_req),
    .dm_req      (dm_req),
    .dstreak_max (dstreak_max),
    .any_req     (pick_any),
    .owner       (pick_owner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      owner_reg    <= OWN_IF;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      dstreak_reg  <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      we_reg       <= we_next;
      err_reg      <= err_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      cnt_reg      <= cnt_next;
      dstreak_reg  <= dstreak_next;
      if_rdata_reg <= if_rdata_next;
      dm_rdata_reg <= dm_rdata_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    we_next       = we_reg;
    err_next      = err_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    cnt_next      = cnt_reg;
    dstreak_next  = dstreak_reg;
    if_rdata_next = if_rdata_reg;
    dm_rdata_next = dm_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next = BUSY;
          owner_next = owner_t'(pick_owner);
          cnt_next   = CNT_LOAD;
          if (owner_t'(pick_owner) == OWN_DM) begin
            we_next    = dm_we;
            addr_next  = dm_addr;
            wdata_next = dm_wdata;
            err_next   = word_misaligned(dm_addr[1:0]);
            // Only grants that made a waiting fetch wait again extend the streak.
            if (if_req) begin
              dstreak_next = dstreak_max ? STREAK_MAX : dstreak_reg + SW'(1);
            end else begin
              dstreak_next = '0;
            end
          end else begin
            we_next      = 1'b0;
            addr_next    = if_addr;
            wdata_next   = '0;
            err_next     = 1'b0;
            dstreak_next = '0;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
          if (!we_reg && !err_reg) begin
            if (owner_reg == OWN_IF) begin
              if_rdata_next = mem_rdata;
            end else begin
              dm_rdata_next = mem_rdata;
            end
          end
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy       = (state_reg == BUSY);
  assign first_busy = busy && (cnt_reg == CNT_LOAD);
  assign done       = (state_reg == DONE);

  assign if_gnt   = first_busy && (owner_reg == OWN_IF);
  assign dm_gnt   = first_busy && (owner_reg == OWN_DM);
  assign if_done  = done && (owner_reg == OWN_IF);
  assign dm_done  = done && (owner_reg == OWN_DM);
  assign dm_err   = dm_done && err_reg;
  assign if_rdata = if_rdata_reg;
  assign dm_rdata = dm_rdata_reg;

  // A misaligned access occupies the slot but never touches memory.
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_read  = busy && !we_reg && !err_reg;
  assign mem_write = busy && we_reg && !err_reg;

  assign cpu_stall = rst_n && ((if_req && !if_done) || (dm_req && !dm_done));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus sequences
// for contention, reset mid-transaction and stall timing at MEM_LAT=3.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_done;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_done, dm_err;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, cpu_stall;

  logic        b_if_req = 1'b0;
  logic [31:0] b_if_addr = '0;
  logic        b_if_gnt, b_if_done;
  logic [31:0] b_if_rdata;
  logic        b_dm_gnt, b_dm_done, b_dm_err;
  logic [31:0] b_dm_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_read, b_mem_write, b_cpu_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .MAX_DSTREAK(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_DSTREAK(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_gnt(b_dm_gnt), .dm_done(b_dm_done), .dm_err(b_dm_err), .dm_rdata(b_dm_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_rdata(b_mem_rdata), .cpu_stall(b_cpu_stall)
  );

  // Memory models: read data is only valid once the read has been held MEM_LAT cycles.
  logic [31:0] mem_model [0:63];
  logic [7:0]  rd_age, b_rd_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 32'h1000_0000 + 32'(i);
      mem_model[4] <= 32'h0050_0093;
      rd_age <= 8'd0;
      b_rd_age <= 8'd0;
    end else begin
      if (mem_write) mem_model[mem_addr[7:2]] <= mem_wdata;
      rd_age <= mem_read ? rd_age + 8'd1 : 8'd0;
      b_rd_age <= b_mem_read ? b_rd_age + 8'd1 : 8'd0;
    end
  end

  assign mem_rdata   = (mem_read && rd_age >= 8'(MEM_LAT - 1)) ? mem_model[mem_addr[7:2]] : 32'hBADC_0DE5;
  assign b_mem_rdata = (b_mem_read && b_rd_age >= 8'd2) ? 32'h0000_0013 : 32'hBADC_0DE5;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_if_done;
    logic        e_dm_gnt;
    logic        e_dm_done;
    logic        e_dm_err;
    logic        e_mem_read;
    logic        e_mem_write;
    logic        e_stall;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
    logic [31:0] e_mem_addr;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic start_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ir, db;
    int n;
    logic exp_dm;
    ir = 32'h0050_0093;
    db = 32'hDEAD_BEEF;
    //          ifr if_addr   dmr we dm_addr    dm_wdata      ig id dg dd de mr mw st if_rdata dm_rdata mem_addr
    vecs[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0, 32'h0, 32'h10};
    vecs[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0, 32'h0, 32'h10};
    vecs[3]  = '{1'b0, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ir,    32'h0, 32'h10};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, ir,    32'h0, 32'h10};
    vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, db,           1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    32'h0, 32'h10};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, db,           1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1, ir,    32'h0, 32'h40};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h40, db,           1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, ir,    32'h0, 32'h40};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h40, db,           1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, ir,    32'h0, 32'h40};
    vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    32'h0, 32'h40};
    vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, ir,    32'h0, 32'h40};
    vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, ir,    32'h0, 32'h40};
    vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, ir,    db,    32'h40};
    vecs[13] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h42, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    db,    32'h40};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h42, 32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    db,    32'h42};
    vecs[15] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h42, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    db,    32'h42};
    vecs[16] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h42, 32'h0,        1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, ir,    db,    32'h42};
    vecs[17] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h41, 32'h12345678, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    db,    32'h42};
    vecs[18] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h41, 32'h12345678, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    db,    32'h41};
    vecs[19] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h41, 32'h12345678, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    db,    32'h41};
    vecs[20] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h41, 32'h12345678, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, ir,    db,    32'h41};
    vecs[21] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, ir,    db,    32'h41};
    vecs[22] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1, ir,    db,    32'h40};
    vecs[23] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, ir,    db,    32'h40};
    vecs[24] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h40, 32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, ir,    db,    32'h40};

    // Reset state with requests asserted: everything must read zero.
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = db;
    start_cyc();
    start_cyc();
    #3;
    chk("rst if_gnt", {31'b0, if_gnt}, 32'h0);
    chk("rst dm_gnt", {31'b0, dm_gnt}, 32'h0);
    chk("rst if_done", {31'b0, if_done}, 32'h0);
    chk("rst dm_done", {31'b0, dm_done}, 32'h0);
    chk("rst dm_err", {31'b0, dm_err}, 32'h0);
    chk("rst mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst cpu_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    $display("reset: outputs checked with both requests high");
    start_cyc();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    rst_n = 1'b1;

    // Fetch, store, load, misaligned load/store, reload.
    for (int i = 0; i < NV; i++) begin
      start_cyc();
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      #3;
      chk($sformatf("r%0d if_gnt", i), {31'b0, if_gnt}, {31'b0, vecs[i].e_if_gnt});
      chk($sformatf("r%0d if_done", i), {31'b0, if_done}, {31'b0, vecs[i].e_if_done});
      chk($sformatf("r%0d dm_gnt", i), {31'b0, dm_gnt}, {31'b0, vecs[i].e_dm_gnt});
      chk($sformatf("r%0d dm_done", i), {31'b0, dm_done}, {31'b0, vecs[i].e_dm_done});
      chk($sformatf("r%0d dm_err", i), {31'b0, dm_err}, {31'b0, vecs[i].e_dm_err});
      chk($sformatf("r%0d mem_read", i), {31'b0, mem_read}, {31'b0, vecs[i].e_mem_read});
      chk($sformatf("r%0d mem_write", i), {31'b0, mem_write}, {31'b0, vecs[i].e_mem_write});
      chk($sformatf("r%0d cpu_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("r%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
      chk($sformatf("r%0d dm_rdata", i), dm_rdata, vecs[i].e_dm_rdata);
      chk($sformatf("r%0d mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      $display("vec %0d: if_req=%0b dm_req=%0b we=%0b addr=%08h -> gnt=%0b%0b done=%0b%0b err=%0b rd=%0b wr=%0b stall=%0b",
               i, if_req, dm_req, dm_we, dm_addr, if_gnt, dm_gnt, if_done, dm_done, dm_err,
               mem_read, mem_write, cpu_stall);
    end

    // Contention: both requests held; data gets four grants, then fetch one.
    start_cyc();
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    n = 0;
    for (int c = 0; c < 200 && n < 12; c++) begin
      if (c != 0) start_cyc();
      #3;
      chk("gnt overlap", {31'b0, if_gnt & dm_gnt}, 32'h0);
      if (if_gnt || dm_gnt) begin
        exp_dm = (n % 5) != 4;
        chk($sformatf("grant%0d dm_gnt", n), {31'b0, dm_gnt}, {31'b0, exp_dm});
        $display("grant %0d: %s (expected %s)", n, dm_gnt ? "D" : "I", exp_dm ? "D" : "I");
        n++;
      end
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL contention grants: got %0d expected 12", n);
    end
    start_cyc();
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) start_cyc();

    // Reset in the second cycle of a store, then a normal load.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hCAFE_F00D;
    #3;
    chk("rb c0 cpu_stall", {31'b0, cpu_stall}, 32'h1);
    start_cyc();
    #3;
    chk("rb c1 dm_gnt", {31'b0, dm_gnt}, 32'h1);
    chk("rb c1 mem_write", {31'b0, mem_write}, 32'h1);
    start_cyc();
    rst_n = 1'b0; dm_req = 1'b0;
    #3;
    chk("rb c2 mem_write", {31'b0, mem_write}, 32'h0);
    chk("rb c2 dm_done", {31'b0, dm_done}, 32'h0);
    chk("rb c2 cpu_stall", {31'b0, cpu_stall}, 32'h0);
    start_cyc();
    #3;
    chk("rb c3 dm_done", {31'b0, dm_done}, 32'h0);
    start_cyc();
    rst_n = 1'b1;
    #3;
    chk("rb c4 dm_done", {31'b0, dm_done}, 32'h0);
    chk("rb c4 mem_write", {31'b0, mem_write}, 32'h0);
    start_cyc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    #3;
    chk("rb c5 dm_gnt", {31'b0, dm_gnt}, 32'h0);
    chk("rb c5 cpu_stall", {31'b0, cpu_stall}, 32'h1);
    start_cyc();
    #3;
    chk("rb c6 dm_gnt", {31'b0, dm_gnt}, 32'h1);
    chk("rb c6 mem_read", {31'b0, mem_read}, 32'h1);
    start_cyc();
    #3;
    chk("rb c7 mem_read", {31'b0, mem_read}, 32'h1);
    start_cyc();
    dm_req = 1'b0;
    #3;
    chk("rb c8 dm_done", {31'b0, dm_done}, 32'h1);
    chk("rb c8 dm_err", {31'b0, dm_err}, 32'h0);
    chk("rb c8 dm_rdata", dm_rdata, 32'h0050_0093);
    $display("reset-mid-store: reload dm_rdata=%08h", dm_rdata);

    // Stall timing with MEM_LAT=3: stall cycles 0-3, drops in done cycle 4.
    for (int c = 0; c < 6; c++) begin
      start_cyc();
      if (c == 0) begin b_if_req = 1'b1; b_if_addr = 32'h20; end
      if (c == 5) b_if_req = 1'b0;
      #3;
      chk($sformatf("lat3 c%0d cpu_stall", c), {31'b0, b_cpu_stall}, {31'b0, (c < 4)});
      chk($sformatf("lat3 c%0d if_gnt", c), {31'b0, b_if_gnt}, {31'b0, (c == 1)});
      chk($sformatf("lat3 c%0d if_done", c), {31'b0, b_if_done}, {31'b0, (c == 4)});
      chk($sformatf("lat3 c%0d mem_read", c), {31'b0, b_mem_read}, {31'b0, (c >= 1 && c <= 3)});
      $display("lat3 cycle %0d: stall=%0b gnt=%0b done=%0b rd=%0b",
               c, b_cpu_stall, b_if_gnt, b_if_done, b_mem_read);
    end
    chk("lat3 if_rdata", b_if_rdata, 32'h0000_0013);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
